// File: rtl/injection_campaign_ctrl_if.sv
// Interface bundling the harness and target-side signals of the
// fault-injection campaign sequencer.
//   master : test harness / target side (drives start, inj_*, dut_y, gold_y)
//   slave  : campaign controller (drives target reset, stimulus, strobe, results)
interface injection_campaign_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             inj_en;
   logic [CNT_W-1:0] inj_idx;
   logic [1:0]       dut_y;
   logic [1:0]       gold_y;
   logic             dut_rstn;
   logic [5:0]       dut_in;
   logic             fault_inj;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [CNT_W-1:0] first_fail_idx;
   logic             first_fail_vld;

   modport master (
      output start, inj_en, inj_idx, dut_y, gold_y,
      input  dut_rstn, dut_in, fault_inj, busy, done, pass,
             mismatch_cnt, first_fail_idx, first_fail_vld
   );

   modport slave (
      input  start, inj_en, inj_idx, dut_y, gold_y,
      output dut_rstn, dut_in, fault_inj, busy, done, pass,
             mismatch_cnt, first_fail_idx, first_fail_vld
   );
endinterface

// File: rtl/injection_campaign_ctrl.sv
// Fault-injection campaign sequencer.
// Holds target and golden model in reset, streams N_VEC LFSR vectors onto the
// target inputs, optionally fires one fault strobe at a programmed index, and
// compares target against golden outputs CMP_LAT edges after each launch.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave modport: start/inj_en/inj_idx/dut_y/gold_y in;
//          dut_rstn/dut_in/fault_inj/busy/done/pass/mismatch_cnt/
//          first_fail_idx/first_fail_vld out
module injection_campaign_ctrl #(
   parameter int unsigned N_VEC   = 256,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned RST_CYC = 2,
   parameter int unsigned CMP_LAT = 2,
   parameter logic [7:0]  SEED    = 8'hA5
) (
   input logic                      clk,
   input logic                      rst,
   injection_campaign_ctrl_if.slave bus
);
   localparam int unsigned      TMAX     = (RST_CYC > CMP_LAT) ? RST_CYC : CMP_LAT;
   localparam int unsigned      TW       = $clog2(TMAX + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);
   localparam logic [TW-1:0]    RST_LAST = TW'(RST_CYC - 1);
   localparam logic [TW-1:0]    DRN_LAST = TW'(CMP_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state, state_n;
   logic [TW-1:0]    tmr;
   logic [CNT_W-1:0] vidx;
   logic [7:0]       lfsr;
   logic             fb;
   logic             inj_en_q;
   logic [CNT_W-1:0] inj_idx_q;
   logic             rstn_q;
   logic             launch;
   logic [CNT_W-1:0] launch_idx;
   logic             pv   [CMP_LAT];
   logic [CNT_W-1:0] pidx [CMP_LAT];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] ffi_q;
   logic             ffv_q;
   logic             pass_q;

   // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
   assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (bus.start)       state_n = S_RESET;
         S_RESET: if (tmr == RST_LAST) state_n = S_RUN;
         S_RUN:   if (vidx == LAST_IDX) state_n = S_DRAIN;
         S_DRAIN: if (tmr == DRN_LAST) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // A vector is launched on every edge that enters (or stays in) RUN; its
   // index rides the compare pipeline so the check lands CMP_LAT edges later.
   always_comb begin
      launch     = (state_n == S_RUN);
      launch_idx = (state == S_RUN) ? vidx + 1'b1 : '0;
   end

   always_comb begin
      bus.busy           = (state != S_IDLE);
      bus.done           = (state == S_DONE);
      bus.dut_in         = (state == S_RUN) ? lfsr[5:0] : '0;
      bus.fault_inj      = (state == S_RUN) && inj_en_q && (vidx == inj_idx_q);
      bus.dut_rstn       = rstn_q;
      bus.pass           = pass_q;
      bus.mismatch_cnt   = cnt_q;
      bus.first_fail_idx = ffi_q;
      bus.first_fail_vld = ffv_q;
   end

   // Phase timer for RESET and DRAIN, restarted on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   tmr <= '0;
      else if (state_n != state) tmr <= '0;
      else                       tmr <= tmr + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr      <= SEED;
         vidx      <= '0;
         inj_en_q  <= 1'b0;
         inj_idx_q <= '0;
         rstn_q    <= 1'b0;
      end else begin
         rstn_q <= (state_n != S_RESET);
         case (state)
            S_IDLE: begin
               lfsr <= SEED;
               vidx <= '0;
               if (bus.start) begin
                  inj_en_q  <= bus.inj_en;
                  inj_idx_q <= bus.inj_idx;
               end
            end
            S_RUN: begin
               lfsr <= {lfsr[6:0], fb};
               vidx <= vidx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < CMP_LAT; k++) begin
            pv[k]   <= 1'b0;
            pidx[k] <= '0;
         end
      end else begin
         pv[0]   <= launch;
         pidx[0] <= launch_idx;
         for (int unsigned k = 1; k < CMP_LAT; k++) begin
            pv[k]   <= pv[k-1];
            pidx[k] <= pidx[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         ffi_q  <= '0;
         ffv_q  <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         if (state == S_IDLE && bus.start) begin
            cnt_q  <= '0;
            ffv_q  <= 1'b0;
            pass_q <= 1'b0;
         end else if (pv[CMP_LAT-1] && (bus.dut_y != bus.gold_y)) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (!ffv_q) begin
               ffv_q <= 1'b1;
               ffi_q <= pidx[CMP_LAT-1];
            end
         end
         if (state == S_DONE) pass_q <= (cnt_q == '0);
      end
   end
endmodule

// File: tb/tb_injection_campaign_ctrl.sv
// Scoreboard bench for injection_campaign_ctrl: stimulus pushes the expected
// campaign outcome, a monitor follows the DUT cycle by cycle and compares.
module tb_injection_campaign_ctrl;
   localparam int unsigned N  = 16;
   localparam int unsigned CW = 16;
   localparam int unsigned RC = 2;
   localparam int unsigned CL = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   injection_campaign_ctrl_if #(.CNT_W(CW)) bus ();
   injection_campaign_ctrl_if #(.CNT_W(3))  bus2 ();

   injection_campaign_ctrl #(
      .N_VEC(N), .CNT_W(CW), .RST_CYC(RC), .CMP_LAT(CL), .SEED(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   injection_campaign_ctrl #(
      .N_VEC(7), .CNT_W(3), .RST_CYC(1), .CMP_LAT(1), .SEED(8'hA5)
   ) dut_small (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
   endtask

   // Target model with one register stage (response visible CL edges after launch).
   logic [5:0]  t_v = '0;
   logic        t_f = 1'b0;
   logic [63:0] bad_pat = '0;
   logic [1:0]  flip_m = 2'b01;

   function automatic logic [1:0] gfun(input logic [5:0] v);
      return {v[5] ^ v[3] ^ v[1], (v[4] & v[2]) | v[0]};
   endfunction

   always @(posedge clk) begin
      t_v <= bus.dut_in;
      t_f <= bus.fault_inj;
   end
   assign bus.gold_y = gfun(t_v);
   assign bus.dut_y  = gfun(t_v) ^ (bad_pat[t_v] ? flip_m : 2'b00) ^ {1'b0, t_f};
   assign bus2.gold_y = 2'b00;
   assign bus2.dut_y  = 2'b01;

   // Reference model
   logic [5:0] vec [N];

   typedef struct {
      bit inj_en;
      int inj_idx;
      int cnt;
      bit ffv;
      int ffi;
      bit pass;
   } exp_t;

   exp_t sbq [$];

   function automatic exp_t model(input bit en, input int idx, input logic [63:0] bad,
                                  input logic [1:0] flip);
      exp_t       r;
      logic [1:0] m;
      r.inj_en = en; r.inj_idx = idx; r.cnt = 0; r.ffv = 0; r.ffi = 0;
      for (int i = 0; i < N; i++) begin
         m = (bad[vec[i]] ? flip : 2'b00) ^ ((en && idx == i) ? 2'b01 : 2'b00);
         if (m != 2'b00) begin
            if (r.cnt < (1 << CW) - 1) r.cnt++;
            if (!r.ffv) begin r.ffv = 1; r.ffi = i; end
         end
      end
      r.pass = (r.cnt == 0);
      return r;
   endfunction

   // Monitor
   initial begin : monitor
      exp_t e;
      exp_t last;
      bit   active = 0;
      bit   prev_busy = 0;
      int   k = 0;
      int   since_rst = 0;
      int   i;
      last = '{default: 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 0; prev_busy = 0; since_rst = 0; last = '{default: 0};
            chk("rst_rstn", bus.dut_rstn, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_pass", bus.pass, 0);
            chk("rst_din", bus.dut_in, 0);
            chk("rst_fault", bus.fault_inj, 0);
            chk("rst_cnt", bus.mismatch_cnt, 0);
            chk("rst_ffi", bus.first_fail_idx, 0);
            chk("rst_ffv", bus.first_fail_vld, 0);
         end else begin
            if (!active && bus.busy && !prev_busy) begin
               if (sbq.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_start: busy rose with scoreboard size 0, required >0");
               end else begin
                  e = sbq.pop_front(); active = 1; k = 0;
               end
            end
            if (active) begin
               if (k < RC) begin
                  chk("reset_rstn", bus.dut_rstn, 0);
                  chk("reset_din", bus.dut_in, 0);
                  chk("reset_busy", bus.busy, 1);
                  chk("reset_fault", bus.fault_inj, 0);
               end else if (k < RC + N) begin
                  i = k - RC;
                  chk("run_din", bus.dut_in, vec[i]);
                  chk("run_fault", bus.fault_inj, (e.inj_en && e.inj_idx == i));
                  chk("run_rstn", bus.dut_rstn, 1);
                  chk("run_busy", bus.busy, 1);
                  chk("run_done", bus.done, 0);
               end else if (k < RC + N + CL) begin
                  chk("drain_din", bus.dut_in, 0);
                  chk("drain_fault", bus.fault_inj, 0);
                  chk("drain_done", bus.done, 0);
                  chk("drain_busy", bus.busy, 1);
               end else if (k == RC + N + CL) begin
                  chk("done_pulse", bus.done, 1);
                  chk("done_busy", bus.busy, 1);
               end else begin
                  chk("end_busy", bus.busy, 0);
                  chk("end_done", bus.done, 0);
                  chk("end_pass", bus.pass, e.pass);
                  chk("end_cnt", bus.mismatch_cnt, e.cnt);
                  chk("end_ffv", bus.first_fail_vld, e.ffv);
                  if (e.ffv) chk("end_ffi", bus.first_fail_idx, e.ffi);
                  last = e; active = 0;
               end
               k++;
            end else begin
               chk("idle_busy", bus.busy, 0);
               chk("idle_done", bus.done, 0);
               chk("idle_din", bus.dut_in, 0);
               chk("idle_fault", bus.fault_inj, 0);
               chk("idle_rstn", bus.dut_rstn, (since_rst > 0));
               chk("idle_pass", bus.pass, last.pass);
               chk("idle_cnt", bus.mismatch_cnt, last.cnt);
               chk("idle_ffv", bus.first_fail_vld, last.ffv);
            end
            prev_busy = bus.busy;
            since_rst++;
         end
      end
   end

   // Stimulus
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic launch(input bit en, input int idx, input logic [63:0] bad,
                         input logic [1:0] flip, input bit hold);
      bad_pat = bad; flip_m = flip;
      bus.inj_en = en; bus.inj_idx = CW'(idx); bus.start = 1'b1;
      sbq.push_back(model(en, idx, bad, flip));
      tick();
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int maxc);
      int c = 0;
      do begin @(negedge clk); c++; end while (!bus.done && c < maxc);
      if (!bus.done) begin
         checks++;
         $display("FAIL %s: no done within %0d cycles, required done=1", name, maxc);
      end
      tick();
   endtask

   task automatic campaign(input bit en, input int idx, input logic [63:0] bad,
                           input logic [1:0] flip, input bit noise);
      launch(en, idx, bad, flip, 1'b0);
      if (noise) begin
         for (int c = 0; c < N - 2; c++) begin
            bus.start   = 1'($urandom_range(0, 1));
            bus.inj_en  = 1'($urandom_range(0, 1));
            bus.inj_idx = CW'($urandom_range(0, 20));
            tick();
         end
         bus.start = 1'b0;
      end
      wait_done("campaign_done", 100);
      repeat ($urandom_range(0, 3)) tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      logic [7:0]  l;
      logic [63:0] bad;
      int          c;
      l = 8'hA5;
      for (int i = 0; i < N; i++) begin
         vec[i] = l[5:0];
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      bus.start = 1'b0; bus.inj_en = 1'b0; bus.inj_idx = '0;
      bus2.start = 1'b0; bus2.inj_en = 1'b0; bus2.inj_idx = '0;
      #1 rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      campaign(1'b0, 0, '0, 2'b01, 1'b0);              // clean target
      campaign(1'b1, 5, '0, 2'b01, 1'b0);              // strobe at vector 5
      campaign(1'b0, 0, '1, 2'b01, 1'b0);              // every response wrong
      campaign(1'b1, 16, '0, 2'b01, 1'b0);             // out-of-range strobe index
      campaign(1'b1, 15, '0, 2'b10, 1'b0);             // strobe on last vector
      campaign(1'b1, 0, '0, 2'b10, 1'b1);              // strobe on first vector, noisy start
      for (int r = 0; r < 8; r++) begin
         bad = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         campaign(1'($urandom_range(0, 1)), $urandom_range(0, 20), bad,
                  2'($urandom_range(1, 3)), 1'b1);
      end

      // back-to-back: start held through DONE relaunches on the next IDLE cycle
      launch(1'b1, 3, '0, 2'b01, 1'b1);
      c = 0;
      do begin @(negedge clk); c++; end while (!bus.done && c < 100);
      sbq.push_back(model(1'b1, 3, '0, 2'b01));
      tick();
      tick();
      bus.start = 1'b0;
      wait_done("b2b_done", 100);
      repeat (2) tick();

      // reset mid-RUN discards the campaign; next start begins from the seed
      launch(1'b0, 0, '0, 2'b01, 1'b0);
      repeat (RC + 5) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (25) tick();
      campaign(1'b1, 9, '0, 2'b11, 1'b0);

      // narrow counter instance: constant mismatch fills but never wraps
      for (int run = 0; run < 2; run++) begin
         bus2.start = 1'b1;
         tick();
         bus2.start = 1'b0;
         c = -1;
         do begin @(negedge clk); c++; end while (!bus2.done && c < 50);
         chk("small_done_lat", c, 9);
         @(negedge clk);
         chk("small_busy_end", bus2.busy, 0);
         chk("small_cnt", bus2.mismatch_cnt, 7);
         chk("small_ffv", bus2.first_fail_vld, 1);
         chk("small_ffi", bus2.first_fail_idx, 0);
         chk("small_pass", bus2.pass, 0);
         repeat (4) @(negedge clk);
         chk("small_cnt_hold", bus2.mismatch_cnt, 7);
         tick();
      end

      repeat (3) tick();
      chk("sb_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/injection_campaign_ctrl.md
# injection_campaign_ctrl

Sequencer for one fault-injection validation campaign on the two-output injection target:
- Holds the target and its golden model in reset.
- Drives a pseudo-random stream of 6-bit stimulus vectors onto target inputs {a,b,c,d,e,f}.
- Optionally fires a single fault-injection strobe at a programmed vector index.
- Compares target outputs against golden-model outputs and reports mismatch statistics.

It sits between the test harness (start/results) and the target plus golden model.

## Interface
- N_VEC, 256: vectors per campaign (≥1).
- CNT_W, 16: width of index/counter ports; 2^CNT_W must exceed N_VEC.
- RST_CYC, 2: cycles target reset is held at campaign start (≥1).
- CMP_LAT, 2: edges from vector launch to the edge that samples the target/golden response (≥1).
- SEED, 8'hA5: LFSR seed (non-zero).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  campaign request, sampled in IDLE only.
- inj_en  in  1  enable fault strobe; sampled with start.
- inj_idx  in  CNT_W  vector index at which the fault strobe fires; sampled with start.
- dut_y  in  2  target outputs {y2,y1}.
- gold_y  in  2  golden-model outputs {y2,y1}.
- dut_rstn  out  1  active-low reset to target and golden model.
- dut_in  out  6  stimulus {a,b,c,d,e,f} = lfsr[5:0].
- fault_inj  out  1  one-cycle fault strobe.
- busy  out  1  campaign in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  last campaign had zero mismatches.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- first_fail_idx  out  CNT_W  vector index of first mismatch.
- first_fail_vld  out  1  first_fail_idx is valid.

## Operation
FSM states: IDLE, RESET, RUN, DRAIN, DONE.

- **IDLE**
  - start=1 → RESET.
  - Latch inj_en and inj_idx.
  - Clear mismatch_cnt, first_fail_vld and pass.
  - Load LFSR with SEED.
- **RESET**
  - dut_rstn=0 for exactly RST_CYC cycles, then → RUN.
- **RUN**
  - One vector per cycle, index 0..N_VEC-1.
  - Vector i = LFSR state after i advances. Vector 0 = SEED[5:0].
  - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  - After vector N_VEC-1 → DRAIN.
- **DRAIN**
  - Hold for CMP_LAT cycles so trailing responses are compared, then → DONE.
- **DONE**
  - done=1 for one cycle.
  - pass ← (mismatch_cnt==0).
  - → IDLE.

Outputs outside RUN:
- dut_in = 0.
- fault_inj = 0.

Fault strobe:
- fault_inj=1 during the RUN cycle driving vector inj_idx, only if the latched inj_en=1.
- inj_idx ≥ N_VEC means no strobe.

Compare pipeline:
- A CMP_LAT-deep shift register carries {valid, index} for each launched vector.
- On the edge where valid exits the pipeline, the block compares dut_y against gold_y.
- On inequality:
  - mismatch_cnt increments, saturating at all-ones.
  - If first_fail_vld=0, capture the index and set first_fail_vld.
- No compares occur outside this pipeline.

Other rules:
- start while busy is ignored; latched parameters do not change mid-campaign.
- busy=1 in RESET, RUN, DRAIN and DONE.
- Results hold after DONE until the next accepted start.
- rst at any time asynchronously forces all registers and outputs to reset values. Any partial campaign is discarded, and no done pulse is issued for it.

## Timing
Reset values:
- dut_rstn=0.
- dut_in=0, fault_inj=0.
- busy=0, done=0, pass=0.
- mismatch_cnt=0, first_fail_idx=0, first_fail_vld=0.
- FSM in IDLE, LFSR=SEED.

After rst deasserts, dut_rstn rises on the first clock edge (IDLE drives 1).

Campaign timing, with start sampled at edge t:
- busy=1 and dut_rstn=0 from t.
- Vector 0 appears on dut_in after edge t+RST_CYC.
- Vector i is compared at edge t+RST_CYC+i+CMP_LAT.
- done is high during the cycle after edge t+RST_CYC+N_VEC+CMP_LAT.
- busy falls, and pass becomes valid, with done's falling edge.
- Total busy duration = RST_CYC+N_VEC+CMP_LAT+1 cycles.

Back-to-back: start held high re-launches on the first IDLE cycle after DONE.

## Test plan
1. Assert rst mid-sequence, then release → all outputs at reset values, dut_rstn=1 one edge after release, no done pulse.
2. N_VEC=16, correct target, inj_en=0 → first dut_in=6'h25; done 21 cycles after start; pass=1, mismatch_cnt=0, first_fail_vld=0.
3. N_VEC=16, inj_en=1, inj_idx=5, target model forces y1 inverted while fault_inj is seen → fault_inj high exactly in the vector-5 cycle; first_fail_idx=5, first_fail_vld=1, pass=0.
4. dut_y = gold_y ^ 2'b01 constantly, N_VEC=16 → mismatch_cnt=16, first_fail_idx=0. Repeat with CNT_W=3, N_VEC=7 → mismatch_cnt=7 and holds, no wrap.
5. start pulses during RUN → ignored, timing unchanged. Then rst mid-RUN followed by a new start → identical vector sequence starting at 6'h25.
6. inj_en=1, inj_idx=16, N_VEC=16 → fault_inj never asserts; results identical to scenario 2.
